// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a registered 4:1 data mux.
// A grant is held, with f, gnt and the mux selects frozen, until the consumer
// accepts f (f_valid && out_ready). On that handshake the pointer moves past
// the served requester, and a new winner is loaded in the same cycle if any
// request is present, so back-to-back traffic runs at one transfer per cycle.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    output logic [3:0]       gnt,
    output logic [3:0]       ack,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    // Mux select code, packed as {sel3, sel1, sel2}.
    localparam logic [2:0] SelA = 3'b110;
    localparam logic [2:0] SelB = 3'b100;
    localparam logic [2:0] SelC = 3'b001;
    localparam logic [2:0] SelD = 3'b000;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;

    logic             handshake;
    logic [1:0]       gnt_idx;
    logic [1:0]       base;
    logic [3:0]       req_rot;
    logic [1:0]       win_off;
    logic [1:0]       win_idx;
    logic             win_valid;
    logic [WIDTH-1:0] win_data;
    logic [3:0]       win_onehot;
    logic [2:0]       win_sel;

    // Encode the held one-hot grant and pick the search origin for arbitration.
    always_comb begin
        handshake = (state_q == StHold) && out_ready;
        gnt_idx   = 2'd0;
        unique case (gnt_q)
            4'b0001: gnt_idx = 2'd0;
            4'b0010: gnt_idx = 2'd1;
            4'b0100: gnt_idx = 2'd2;
            4'b1000: gnt_idx = 2'd3;
            default: gnt_idx = 2'd0;
        endcase
        // On a handshake the just-served requester drops to lowest priority.
        base = handshake ? (gnt_idx + 2'd1) : ptr_q;
    end

    // Rotate req so that the origin sits at bit 0, then take the first set bit.
    always_comb begin
        req_rot = req;
        case (base)
            2'd0:    req_rot = req;
            2'd1:    req_rot = {req[0], req[3:1]};
            2'd2:    req_rot = {req[1:0], req[3:2]};
            default: req_rot = {req[2:0], req[3]};
        endcase

        win_valid = |req_rot;
        win_off   = 2'd0;
        if (req_rot[0]) begin
            win_off = 2'd0;
        end else if (req_rot[1]) begin
            win_off = 2'd1;
        end else if (req_rot[2]) begin
            win_off = 2'd2;
        end else begin
            win_off = 2'd3;
        end
        win_idx = base + win_off;
    end

    // Decode the winning index into data, one-hot grant and mux select code.
    always_comb begin
        win_data   = a;
        win_onehot = 4'b0001;
        win_sel    = SelA;
        case (win_idx)
            2'd0: begin
                win_data   = a;
                win_onehot = 4'b0001;
                win_sel    = SelA;
            end
            2'd1: begin
                win_data   = b;
                win_onehot = 4'b0010;
                win_sel    = SelB;
            end
            2'd2: begin
                win_data   = c;
                win_onehot = 4'b0100;
                win_sel    = SelC;
            end
            default: begin
                win_data   = d;
                win_onehot = 4'b1000;
                win_sel    = SelD;
            end
        endcase
    end

    // Next-state logic: load a winner from IDLE, hold while stalled, re-arbitrate on handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        f_d     = f_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StHold;
                    f_d     = win_data;
                    gnt_d   = win_onehot;
                    sel_d   = win_sel;
                end
            end
            StHold: begin
                if (out_ready) begin
                    ptr_d = base;
                    if (win_valid) begin
                        state_d = StHold;
                        f_d     = win_data;
                        gnt_d   = win_onehot;
                        sel_d   = win_sel;
                    end else begin
                        // f keeps its last value; only the qualifiers clear.
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        sel_d   = 3'b000;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any pending transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            f_q     <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            f_q     <= f_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    // Output drive; ack is the combinational handshake qualified grant.
    always_comb begin
        f       = f_q;
        f_valid = (state_q == StHold);
        gnt     = gnt_q;
        ack     = (f_valid && out_ready) ? gnt_q : 4'b0000;
        sel3    = sel_q[2];
        sel1    = sel_q[1];
        sel2    = sel_q[0];
    end

endmodule
